uart_tx_fsm: RTL and testbench

Serial transmitter for the UART link. It sits directly upstream of the receiver FSM and drives the receiver's serial input. Parallel words arrive through a valid/ready handshake into a one-deep holding buffer. Each word is serialized as start bit, data MSB-first, even-parity bit and stop bits, and a frame starts only while the receiver signals clear-to-send.

---
 rtl/uart_tx_fsm.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART serial transmitter: one-deep holding buffer, start / MSB-first data /
// even parity / stop framing, gated on clear-to-send at each frame start.
module uart_tx_fsm #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 2,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Tx_Valid,
  input  logic [DATA_BITS-1:0] Tx_Data,
  output logic                 Tx_Ready,
  input  logic                 CTS,
  output logic                 Tx_Out,
  output logic                 Tx_Busy,
  output logic                 Tx_Done
);

  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_d;
  logic [BAUD_W-1:0]    baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full, hold_full_d;
  logic                 parity, parity_d;
  logic                 tx_out_d;
  logic                 done_d;
  logic                 load;
  logic                 accept;
  logic                 bit_end;

  assign accept   = Tx_Valid && !hold_full;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign Tx_Ready = !hold_full;
  assign Tx_Busy  = (state != IDLE);

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    parity_d   = parity;
    load       = 1'b0;
    done_d     = 1'b0;

    if (state != IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_full && CTS) load = 1'b1;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
            shift_d   = shift << 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            done_d = 1'b1;
            if (hold_full && CTS) load = 1'b1;
            else                  state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = START;
      shift_d  = hold_data;
      parity_d = ^hold_data;
    end

    // Any state entry (including Stop->Start on a back-to-back load) restarts both counters.
    if (state_d != state || load) begin
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end

    case (state_d)
      IDLE:    tx_out_d = 1'b1;
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[DATA_BITS-1];
      PARITY:  tx_out_d = parity_d;
      STOP:    tx_out_d = 1'b1;
      default: tx_out_d = 1'b1;
    endcase
  end

  always_comb begin
    hold_full_d = hold_full;
    if (load)        hold_full_d = 1'b0;
    else if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
      Tx_Out    <= 1'b1;
      Tx_Done   <= 1'b0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shift     <= shift_d;
      parity    <= parity_d;
      hold_full <= hold_full_d;
      Tx_Out    <= tx_out_d;
      Tx_Done   <= done_d;
      if (accept) hold_data <= Tx_Data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: two instances (1 and 4 clocks per bit) checked each
// cycle against a frame-position model, plus literal frame checks.
module tb_uart_tx_fsm;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       r[2];
  logic       v[2];
  logic       c[2];
  logic [7:0] d[2];
  logic       rdy[2];
  logic       out[2];
  logic       busy[2];
  logic       done[2];

  int total = 0;
  int bad   = 0;

  uart_tx_fsm #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(1)) dut0 (
    .Clk(Clk), .Rst(r[0]), .Tx_Valid(v[0]), .Tx_Data(d[0]), .Tx_Ready(rdy[0]),
    .CTS(c[0]), .Tx_Out(out[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0])
  );

  uart_tx_fsm #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(4)) dut1 (
    .Clk(Clk), .Rst(r[1]), .Tx_Valid(v[1]), .Tx_Data(d[1]), .Tx_Ready(rdy[1]),
    .CTS(c[1]), .Tx_Out(out[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1])
  );

  // Model: a frame is a 12-entry bit list; the line shows entry pos/cpb.
  int       cpb[2] = '{1, 4};
  bit       m_full[2];
  bit       m_busy[2];
  bit       m_done[2];
  bit [7:0] m_data[2];
  bit [11:0] m_frm[2];
  int       m_pos[2];

  function automatic bit [11:0] build(input bit [7:0] x);
    bit [11:0] f;
    f[0] = 1'b0;
    for (int b = 0; b < 8; b++) f[1+b] = x[7-b];
    f[9]  = ^x;
    f[10] = 1'b1;
    f[11] = 1'b1;
    return f;
  endfunction

  always @(posedge Clk) begin
    bit acc;
    for (int i = 0; i < 2; i++) begin
      if (r[i]) begin
        m_full[i] = 1'b0;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_pos[i]  = 0;
      end else begin
        acc       = v[i] && !m_full[i];
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_pos[i]++;
          if (m_pos[i] == 12 * cpb[i]) begin
            m_done[i] = 1'b1;
            m_busy[i] = 1'b0;
          end
        end
        if (!m_busy[i] && m_full[i] && c[i]) begin
          m_frm[i]  = build(m_data[i]);
          m_pos[i]  = 0;
          m_busy[i] = 1'b1;
          m_full[i] = 1'b0;
        end
        if (acc) begin
          m_full[i] = 1'b1;
          m_data[i] = d[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), 64'(rdy[i]),  64'(!m_full[i]));
      chk($sformatf("busy%0d", i),  64'(busy[i]), 64'(m_busy[i]));
      chk($sformatf("done%0d", i),  64'(done[i]), 64'(m_done[i]));
      chk($sformatf("out%0d", i),   64'(out[i]),
          64'(m_busy[i] ? m_frm[i][m_pos[i] / cpb[i]] : 1'b1));
    end
  end

  task automatic send(input int i, input bit [7:0] x);
    int n = 0;
    while (!rdy[i] && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL send_timeout inst=%0d ready=%0b required=1", i, rdy[i]);
    end
    v[i] = 1'b1;
    d[i] = x;
    @(negedge Clk);
    v[i] = 1'b0;
  endtask

  task automatic capture(input int i, input int n, output logic [63:0] s, output int dn);
    s  = '0;
    dn = 0;
    repeat (n) begin
      @(negedge Clk);
      s  = {s[62:0], out[i]};
      dn += int'(done[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] s;
    logic [63:0] e;
    logic [11:0] f;
    int          dn, cnt, hi, rises;
    logic        prev;

    for (int i = 0; i < 2; i++) begin
      r[i] = 1'b1; v[i] = 1'b0; c[i] = 1'b0; d[i] = '0;
    end

    // Reset held with random inputs.
    repeat (6) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        v[i] = 1'($urandom); c[i] = 1'($urandom); d[i] = 8'($urandom);
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("rst_out",   64'(out[i]),  64'd1);
      chk("rst_ready", 64'(rdy[i]),  64'd1);
      chk("rst_busy",  64'(busy[i]), 64'd0);
      chk("rst_done",  64'(done[i]), 64'd0);
      v[i] = 1'b0; c[i] = 1'b0; r[i] = 1'b0;
    end
    repeat (3) @(negedge Clk);

    // Single frame 0xA5.
    c[0] = 1'b1;
    send(0, 8'hA5);
    capture(0, 12, s, dn);
    chk("a5_bits", s, 64'b010100101011);
    chk("a5_no_early_done", 64'(dn), 64'd0);
    @(negedge Clk);
    chk("a5_done", 64'(done[0]), 64'd1);
    @(negedge Clk);
    chk("a5_done_once", 64'(done[0]), 64'd0);

    // Odd-weight data: parity bit 1.
    send(0, 8'h07);
    capture(0, 12, s, dn);
    chk("x07_bits", s, 64'b000000111111);
    repeat (3) @(negedge Clk);

    // Flow control.
    c[0] = 1'b0;
    send(0, 8'h3C);
    cnt = 0;
    repeat (20) begin
      @(negedge Clk);
      if (!rdy[0] && out[0] && !busy[0]) cnt++;
    end
    chk("cts_hold", 64'(cnt), 64'd20);
    c[0] = 1'b1;
    @(negedge Clk);
    chk("cts_start", 64'(out[0]), 64'd0);
    repeat (4) @(negedge Clk);
    c[0] = 1'b0;
    cnt = 0;
    repeat (7) begin
      @(negedge Clk);
      if (busy[0]) cnt++;
    end
    chk("cts_drop_busy", 64'(cnt), 64'd7);
    @(negedge Clk);
    chk("cts_drop_done", 64'(done[0]), 64'd1);
    c[0] = 1'b1;
    repeat (3) @(negedge Clk);

    // Back-to-back 0x00 then 0xFF.
    send(0, 8'h00);
    s = '0; hi = 0; rises = 0; dn = 0; prev = busy[0];
    fork
      begin
        for (int j = 0; j < 40; j++) begin
          @(negedge Clk);
          if (j < 24) s = {s[62:0], out[0]};
          if (busy[0]) hi++;
          if (busy[0] && !prev) rises++;
          prev = busy[0];
          dn += int'(done[0]);
        end
      end
      send(0, 8'hFF);
    join
    chk("b2b_bits", s, 64'b000000000011_011111111011);
    chk("b2b_busy_cycles", 64'(hi), 64'd24);
    chk("b2b_busy_rises", 64'(rises), 64'd1);
    chk("b2b_done_pulses", 64'(dn), 64'd2);

    // Four clocks per bit: 0x81.
    c[1] = 1'b1;
    send(1, 8'h81);
    capture(1, 48, s, dn);
    f = 12'b010000001011;
    e = '0;
    for (int j = 11; j >= 0; j--) repeat (4) e = {e[62:0], f[j]};
    chk("cpb4_bits", s, e);
    chk("cpb4_no_early_done", 64'(dn), 64'd0);
    @(negedge Clk);
    chk("cpb4_done", 64'(done[1]), 64'd1);
    repeat (3) @(negedge Clk);

    // Reset during the third data bit, with a second word buffered.
    send(1, 8'h5A);
    send(1, 8'hC3);
    repeat (11) @(negedge Clk);
    chk("pre_rst_out", 64'(out[1]), 64'd0);
    chk("pre_rst_full", 64'(rdy[1]), 64'd0);
    #2 r[1] = 1'b1;
    #1;
    chk("rst_async_out", 64'(out[1]), 64'd1);
    chk("rst_async_busy", 64'(busy[1]), 64'd0);
    @(negedge Clk);
    r[1] = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", 64'(rdy[1]), 64'd1);
    chk("post_rst_busy", 64'(busy[1]), 64'd0);
    repeat (10) @(negedge Clk);

    // Random traffic on both instances.
    repeat (1500) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        v[i] = ($urandom_range(0, 3) == 0);
        d[i] = 8'($urandom);
        c[i] = ($urandom_range(0, 4) != 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; c[i] = 1'b1;
    end
    repeat (150) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
